row_scanout: RTL and testbench
==============================

Name: row_scanout

Overview:
- Display-side reader of the double-buffered 24-bit row buffer that the row drawer fills.
- Generates 640x480 VGA timing and reads one finished row per line from the display half of the buffer.
- Drives RGB, sync and blank outputs to the DAC.
- Issues the `swap` / `swap_screen` pulses that restart the drawer on the next row, and flips the ping-pong buffer select.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- ROW_WIDTH, 480, pixels taken from the row buffer (≤512); columns ROW_WIDTH..H_ACTIVE-1 show BORDER_RGB
- BORDER_RGB, 24'h000000, colour outside ROW_WIDTH

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- address_read_row  out  9  row buffer read address (display half)
- data_read_row  in  24  row buffer read data, valid 1 clk after address
- row_sel  out  1  buffer half being displayed; drawer writes the other half
- swap  out  1  one-clk pulse: drawer starts next row
- swap_screen  out  1  one-clk pulse: drawer restarts at row 0
- vga_rgb  out  24  {R[7:0],G[7:0],B[7:0]}
- vga_hsync  out  1  active-low
- vga_vsync  out  1  active-low
- vga_blank_n  out  1  high during visible pixels

Behaviour:
- Reset (async, rst_n=0):
  - h_cnt=0, v_cnt=0, row_sel=0
  - swap=0, swap_screen=0, address_read_row=0
  - vga_rgb=0, vga_hsync=1, vga_vsync=1, vga_blank_n=0
  - Assertion mid-frame aborts immediately; after release the frame restarts at h=0,v=0.
  - No swap pulse is issued until the first swap_screen.
- Counters:
  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL analogous (525).
  - h_cnt increments every clk and wraps at H_TOTAL-1 to 0.
  - v_cnt increments on the h wrap and wraps at V_TOTAL-1 to 0.
- Read address: address_read_row = h_cnt[8:0] while h_cnt<ROW_WIDTH, else holds ROW_WIDTH-1.
- Pipeline, stage 0 (counters) → stage 1 (RAM data) → stage 2 (registered outputs):
  - Fixed latency of 2 clks from h_cnt/v_cnt to the vga_* outputs.
  - Sync and blank are delayed through the same 2 stages so all outputs stay aligned.
- Output decode, using stage-1 values:
  - vga_blank_n = (h<H_ACTIVE)&(v<V_ACTIVE)
  - vga_rgb = data_read_row if visible and h<ROW_WIDTH; BORDER_RGB if visible and h≥ROW_WIDTH; 0 when blanked
  - vga_hsync = 0 for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - vga_vsync: same rule on v
- Swap scheduling, evaluated at h_cnt==H_ACTIVE:
  - v_cnt==V_TOTAL-1: swap_screen=1 for 1 clk, row_sel toggles. Drawer renders row 0 during the last blank line.
  - v_cnt in 0..V_ACTIVE-2: swap=1 for 1 clk, row_sel toggles. Drawer renders row v+1 while row v finishes displaying.
  - v_cnt==V_ACTIVE-1 or vertical blanking (except the last line): no pulse, row_sel unchanged.
  - swap and swap_screen are never high together.
  - Exactly V_ACTIVE-1 swap pulses and 1 swap_screen pulse per frame.
- Toggle timing: row_sel toggles on the same clk the pulse is asserted. Pixels already in flight (h≥H_ACTIVE) are blanked, so the toggle is invisible.
- Wrap corner: the clock where both h and v wrap produces no pulse; the next frame's line 0 displays the half written after swap_screen.

Optional Feature:
- Macro: ROW_SCANOUT_CLEAR_EN
- Enabled:
  - Extra ports clr_address (9, out), clr_data (24, out), clr_wren (1, out).
  - Each displayed buffer pixel is written back with BORDER_RGB at the same address in the same half (clr_address = address delayed 1 clk, clr_wren=1 for h in 0..ROW_WIDTH-1).
  - Result: every half is blank when handed back to the drawer.
  - clr_wren=0 in reset and during blanking.
- Disabled:
  - Ports absent.
  - Buffer contents persist and the drawer is responsible for the background.

Test Plan:
- Reset release, observe 2 frames:
  - hsync low 96 clks every 800 clks, starting at h=656.
  - vsync low for lines 490–491; 420000 clks per frame.
- Row buffer preloaded with data=address:
  - Line 5, h=10 → vga_rgb=24'h00000A two clks after h_cnt=10.
  - h=500 → BORDER_RGB.
- Count pulses over one frame:
  - swap=479, swap_screen=1 (at v=524, h=640).
  - No pulse at v=479; row_sel toggles 480 times.
- Assert rst_n=0 at v=200, h=300 for 3 clks:
  - All outputs take reset values asynchronously.
  - After release, the first pulse is swap_screen at v=524; no swap before it.
- ROW_SCANOUT_CLEAR_EN with BORDER_RGB=24'h102030, one line:
  - clr_wren high for exactly 480 clks.
  - clr_address runs 0..479; rereading that half returns 24'h102030.
- Probe every clk over a frame → swap & swap_screen never simultaneously 1; vga_blank_n=0 ⇒ vga_rgb=0.

Source files
------------

// File: rtl/row_scanout.sv
// Display-side reader of the ping-pong 24-bit row buffer: VGA timing, 2-clk output pipeline,
// and the swap/swap_screen pulses for the drawer. Optional write-back clear: ROW_SCANOUT_CLEAR_EN.
module row_scanout #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned ROW_WIDTH  = 480,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [8:0]  address_read_row,
  input  logic [23:0] data_read_row,
  output logic        row_sel,
  output logic        swap,
  output logic        swap_screen,
  output logic [23:0] vga_rgb,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n
`ifdef ROW_SCANOUT_CLEAR_EN
  ,
  output logic [8:0]  clr_address,
  output logic [23:0] clr_data,
  output logic        clr_wren
`endif
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CNT_W    = 12;
  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned RGB_W    = 24;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  // stage 0: counters and scheduling state
  logic [CNT_W-1:0]  h_cnt, v_cnt;
  logic [CNT_W-1:0]  h_nxt, v_nxt;
  logic              armed;
  logic              armed_nxt;
  logic              swap_nxt, swap_screen_nxt, row_sel_nxt;
  logic              line_swap_point;
  logic [ADDR_W-1:0] addr_nxt;

  // stage 0 decode, captured into stage 1
  logic vis_s0, row_s0, hs_s0, vs_s0;
  logic vis_s1, row_s1, hs_s1, vs_s1;

  // stage 2 next values
  logic [RGB_W-1:0] rgb_nxt;

  // Counter advance; v moves only on the h wrap.
  always_comb begin
    h_nxt = h_cnt + CNT_W'(1);
    v_nxt = v_cnt;
    if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
      h_nxt = '0;
      if (v_cnt == CNT_W'(V_TOTAL - 1)) begin
        v_nxt = '0;
      end else begin
        v_nxt = v_cnt + CNT_W'(1);
      end
    end
  end

  // Pulses are computed from next counter values so they are high while h_cnt==H_ACTIVE.
  always_comb begin
    line_swap_point = (h_nxt == CNT_W'(H_ACTIVE));
    swap_screen_nxt = line_swap_point && (v_nxt == CNT_W'(V_TOTAL - 1));
    swap_nxt        = line_swap_point && armed && (v_nxt <= CNT_W'(V_ACTIVE - 2));
    armed_nxt       = armed | swap_screen_nxt;
    row_sel_nxt     = row_sel ^ (swap_nxt | swap_screen_nxt);
    if (h_nxt < CNT_W'(ROW_WIDTH)) begin
      addr_nxt = ADDR_W'(h_nxt);
    end else begin
      addr_nxt = ADDR_W'(ROW_WIDTH - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt            <= '0;
      v_cnt            <= '0;
      armed            <= 1'b0;
      row_sel          <= 1'b0;
      swap             <= 1'b0;
      swap_screen      <= 1'b0;
      address_read_row <= '0;
    end else begin
      h_cnt            <= h_nxt;
      v_cnt            <= v_nxt;
      armed            <= armed_nxt;
      row_sel          <= row_sel_nxt;
      swap             <= swap_nxt;
      swap_screen      <= swap_screen_nxt;
      address_read_row <= addr_nxt;
    end
  end

  // Visibility and sync decode of the current counter position.
  always_comb begin
    vis_s0 = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
    row_s0 = (h_cnt < CNT_W'(ROW_WIDTH));
    hs_s0  = !((h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_END)));
    vs_s0  = !((v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_END)));
  end

  // stage 1: decode travels alongside the RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vis_s1 <= 1'b0;
      row_s1 <= 1'b0;
      hs_s1  <= 1'b1;
      vs_s1  <= 1'b1;
    end else begin
      vis_s1 <= vis_s0;
      row_s1 <= row_s0;
      hs_s1  <= hs_s0;
      vs_s1  <= vs_s0;
    end
  end

  always_comb begin
    rgb_nxt = '0;
    if (vis_s1) begin
      rgb_nxt = row_s1 ? data_read_row : BORDER_RGB;
    end
  end

  // stage 2: registered DAC outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_rgb     <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      vga_rgb     <= rgb_nxt;
      vga_hsync   <= hs_s1;
      vga_vsync   <= vs_s1;
      vga_blank_n <= vis_s1;
    end
  end

`ifdef ROW_SCANOUT_CLEAR_EN
  // Write BORDER_RGB back over each pixel one clk after it was read, leaving the half blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_address <= '0;
      clr_wren    <= 1'b0;
    end else begin
      clr_address <= address_read_row;
      clr_wren    <= row_s0 && (v_cnt < CNT_W'(V_ACTIVE));
    end
  end

  assign clr_data = BORDER_RGB;
`endif

endmodule

// File: tb/tb_row_scanout.sv
// Directed bench for row_scanout using a reduced timing set (60x27 total) so several frames fit.
module tb_row_scanout;

  localparam int unsigned H_ACTIVE  = 40;
  localparam int unsigned H_FP      = 4;
  localparam int unsigned H_SYNC    = 8;
  localparam int unsigned H_BP      = 8;
  localparam int unsigned V_ACTIVE  = 20;
  localparam int unsigned V_FP      = 2;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 3;
  localparam int unsigned ROW_WIDTH = 30;
  localparam logic [23:0] BORDER    = 24'h102030;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [8:0]  address_read_row;
  logic [23:0] data_read_row;
  logic        row_sel, swap, swap_screen;
  logic [23:0] vga_rgb;
  logic        vga_hsync, vga_vsync, vga_blank_n;
`ifdef ROW_SCANOUT_CLEAR_EN
  logic [8:0]  clr_address;
  logic [23:0] clr_data;
  logic        clr_wren;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int t = 0;

  int n_swap = 0, n_scr = 0, n_tog = 0, n_both = 0, n_blank_rgb = 0, n_hs = 0, n_vs = 0, n_clr = 0;
  int s_swap, s_scr, s_tog, s_hs, s_clr;
  logic prev_rs = 1'b0;

  row_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .ROW_WIDTH(ROW_WIDTH), .BORDER_RGB(BORDER)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .address_read_row(address_read_row),
    .data_read_row(data_read_row),
    .row_sel(row_sel),
    .swap(swap),
    .swap_screen(swap_screen),
    .vga_rgb(vga_rgb),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .vga_blank_n(vga_blank_n)
`ifdef ROW_SCANOUT_CLEAR_EN
    ,
    .clr_address(clr_address),
    .clr_data(clr_data),
    .clr_wren(clr_wren)
`endif
  );

  always #5 clk = ~clk;

  // Row buffer model: both halves hold data == address, one clk read latency.
  always @(posedge clk) data_read_row <= {15'd0, address_read_row};

  // Clocks since reset release; equals the DUT h/v position in raster order.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (swap) n_swap++;
      if (swap_screen) n_scr++;
      if (swap && swap_screen) n_both++;
      if (!vga_blank_n && vga_rgb != 24'h0) n_blank_rgb++;
      if (!vga_hsync) n_hs++;
      if (!vga_vsync) n_vs++;
`ifdef ROW_SCANOUT_CLEAR_EN
      if (clr_wren) n_clr++;
`endif
    end
    if (row_sel != prev_rs) n_tog++;
    prev_rs = row_sel;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_to(input int target);
    while (t != target) @(negedge clk);
    #1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_addr", 32'(address_read_row), 32'd0);
    check("rst_row_sel", 32'(row_sel), 32'd0);
    check("rst_swap", 32'(swap), 32'd0);
    check("rst_swap_screen", 32'(swap_screen), 32'd0);
    check("rst_rgb", 32'(vga_rgb), 32'd0);
    check("rst_hsync", 32'(vga_hsync), 32'd1);
    check("rst_vsync", 32'(vga_vsync), 32'd1);
    check("rst_blank_n", 32'(vga_blank_n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // frame 0: sync timing, pixel pipeline, first swap_screen
    run_to(45);   check("hs_h43", 32'(vga_hsync), 32'd1);
    run_to(46);   check("hs_h44", 32'(vga_hsync), 32'd0);
    run_to(53);   check("hs_h51", 32'(vga_hsync), 32'd0);
    run_to(54);   check("hs_h52", 32'(vga_hsync), 32'd1);
    run_to(312);  check("rgb_v5_h10", 32'(vga_rgb), 32'h00000A);
                  check("blank_v5_h10", 32'(vga_blank_n), 32'd1);
    run_to(315);  check("addr_h15", 32'(address_read_row), 32'd15);
`ifdef ROW_SCANOUT_CLEAR_EN
    run_to(316);  check("clr_addr_h15", 32'(clr_address), 32'd15);
                  check("clr_wren_h15", 32'(clr_wren), 32'd1);
                  check("clr_data", 32'(clr_data), 32'(BORDER));
`endif
    run_to(331);  check("rgb_h29", 32'(vga_rgb), 32'h00001D);
    run_to(337);  check("rgb_border_h35", 32'(vga_rgb), 32'(BORDER));
    run_to(342);  check("rgb_hblank_h40", 32'(vga_rgb), 32'd0);
                  check("blank_h40", 32'(vga_blank_n), 32'd0);
    run_to(345);  check("addr_hold_h45", 32'(address_read_row), 32'(ROW_WIDTH - 1));
    run_to(1212); check("rgb_vblank_v20", 32'(vga_rgb), 32'd0);
    run_to(1321); check("vs_v21", 32'(vga_vsync), 32'd1);
    run_to(1322); check("vs_v22", 32'(vga_vsync), 32'd0);
    run_to(1441); check("vs_v23", 32'(vga_vsync), 32'd0);
    run_to(1442); check("vs_v24", 32'(vga_vsync), 32'd1);
    run_to(1599); check("row_sel_pre_screen", 32'(row_sel), 32'd0);
    run_to(1600); check("swap_screen_v26", 32'(swap_screen), 32'd1);
                  check("row_sel_at_screen", 32'(row_sel), 32'd1);
    run_to(1619);
    check("f0_swaps", 32'(n_swap), 32'd0);
    check("f0_screens", 32'(n_scr), 32'd1);
    check("f0_toggles", 32'(n_tog), 32'd1);
    check("f0_hs_low", 32'(n_hs), 32'd216);
    check("f0_vs_low", 32'(n_vs), 32'd120);
    s_swap = n_swap; s_scr = n_scr; s_tog = n_tog; s_hs = n_hs; s_clr = n_clr;

    // frame 1: fully armed
    run_to(1660); check("swap_v0", 32'(swap), 32'd1);
                  check("row_sel_v0", 32'(row_sel), 32'd0);
    run_to(2740); check("swap_v18", 32'(swap), 32'd1);
    run_to(2800); check("no_swap_v19", 32'(swap), 32'd0);
                  check("no_screen_v19", 32'(swap_screen), 32'd0);
    run_to(3239);
    check("f1_swaps", 32'(n_swap - s_swap), 32'(V_ACTIVE - 1));
    check("f1_screens", 32'(n_scr - s_scr), 32'd1);
    check("f1_toggles", 32'(n_tog - s_tog), 32'(V_ACTIVE));
    check("f1_hs_low", 32'(n_hs - s_hs), 32'd216);
`ifdef ROW_SCANOUT_CLEAR_EN
    check("f1_clr_wren", 32'(n_clr - s_clr), 32'(ROW_WIDTH * V_ACTIVE));
`endif
    check("never_both", 32'(n_both), 32'd0);
    check("blank_rgb_zero", 32'(n_blank_rgb), 32'd0);

    // mid-frame reset at v=8, h=30 of frame 2
    run_to(3240 + 8 * 60 + 30);
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr", 32'(address_read_row), 32'd0);
    check("mid_rst_row_sel", 32'(row_sel), 32'd0);
    check("mid_rst_rgb", 32'(vga_rgb), 32'd0);
    check("mid_rst_blank_n", 32'(vga_blank_n), 32'd0);
    check("mid_rst_hsync", 32'(vga_hsync), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s_swap = n_swap; s_scr = n_scr;
    run_to(1599);
    check("post_rst_no_swap", 32'(n_swap - s_swap), 32'd0);
    check("post_rst_no_screen", 32'(n_scr - s_scr), 32'd0);
    run_to(1600); check("post_rst_screen", 32'(swap_screen), 32'd1);
    run_to(1660); check("post_rst_swap_v0", 32'(swap), 32'd1);
    check("never_both_final", 32'(n_both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
